// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with grant locking: owner keeps the resource until done/req drop.
// Optional hold-time limit: define RR_LOCK_ARBITER_TIMEOUT_EN to force release after MaxHold cycles.
module rr_lock_arbiter #(
  parameter int unsigned NumReq  = 4,
  parameter int unsigned MaxHold = 16,
  parameter int unsigned IdxW    = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic              clk_i,
  input  logic              arst_ni,
  input  logic [NumReq-1:0] req_i,
  input  logic [NumReq-1:0] done_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   gnt_idx_o,
  output logic              busy_o
);

  if (NumReq == 0 || MaxHold == 0) begin : gen_param_check
    $error("rr_lock_arbiter: NumReq and MaxHold must be at least 1");
  end

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [NumReq-1:0] gnt_q, gnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [IdxW:0]     pick_idle, pick_rel;
  logic [31:0]       ptr_nxt;
  logic              owner_rel;
  logic              new_grant;
  logic              timeout;

  // Returns {found, index} of the first set bit searching cyclically upward from start.
  function automatic logic [IdxW:0] rr_pick(input logic [NumReq-1:0] vec,
                                            input logic [IdxW-1:0]   start);
    logic [IdxW:0] res;
    logic [31:0]   k;
    res = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      k = (32'(start) + i) % NumReq;
      if (!res[IdxW] && vec[IdxW'(k)]) res = {1'b1, IdxW'(k)};
    end
    return res;
  endfunction

  assign ptr_nxt   = (32'(idx_q) + 32'd1) % NumReq;
  assign pick_idle = rr_pick(req_i, ptr_q);
  // The current owner is masked so it can never be re-granted back-to-back.
  assign pick_rel  = rr_pick(req_i & ~gnt_q, IdxW'(ptr_nxt));
  assign owner_rel = done_i[idx_q] | ~req_i[idx_q] | timeout;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    new_grant = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_idle[IdxW]) begin
          state_d   = StGrant;
          idx_d     = pick_idle[IdxW-1:0];
          gnt_d     = NumReq'(1) << pick_idle[IdxW-1:0];
          new_grant = 1'b1;
        end
      end
      StGrant: begin
        if (owner_rel) begin
          ptr_d = IdxW'(ptr_nxt);
          if (pick_rel[IdxW]) begin
            idx_d     = pick_rel[IdxW-1:0];
            gnt_d     = NumReq'(1) << pick_rel[IdxW-1:0];
            new_grant = 1'b1;
          end else begin
            state_d = StIdle;
            idx_d   = '0;
            gnt_d   = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
    end
  end

`ifdef RR_LOCK_ARBITER_TIMEOUT_EN
  localparam int unsigned HoldW = $clog2(MaxHold + 1);

  logic [HoldW-1:0] hold_q, hold_d;

  // Counter holds the number of grant cycles already served by the current owner.
  assign timeout = (hold_q == HoldW'(MaxHold - 1));

  always_comb begin
    hold_d = hold_q;
    if (new_grant || (state_q == StGrant && owner_rel)) begin
      hold_d = '0;
    end else if (state_q == StGrant) begin
      hold_d = hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign gnt_o     = gnt_q;
  assign gnt_idx_o = idx_q;
  assign busy_o    = |gnt_q;

endmodule
